// File: rtl/snn_cfg_spi_master_if.sv
// rtl/snn_cfg_spi_master_if.sv - host byte handshake and SPI pin bundle for the config SPI master
interface snn_cfg_spi_master_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  start;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  last;
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  done;
   logic                  busy;
   logic                  sclk;
   logic                  mosi;
   logic                  miso;
   logic                  cs_n;

   modport master (
      input  start, tx_data, last, miso,
      output rx_data, done, busy, sclk, mosi, cs_n
   );

   modport slave (
      output start, tx_data, last, miso,
      input  rx_data, done, busy, sclk, mosi, cs_n
   );
endinterface

// File: rtl/snn_cfg_spi_master.sv
// rtl/snn_cfg_spi_master.sv - mode-0 MSB-first SPI master streaming config bytes into the SNN core
module snn_cfg_spi_master #(
   parameter int CLK_DIV    = 2,
   parameter int DATA_WIDTH = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   snn_cfg_spi_master_if.master        bus
);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SETUP   = 3'd1;
   localparam logic [2:0] S_SHIFT   = 3'd2;
   localparam logic [2:0] S_HOLD    = 3'd3;
   localparam logic [2:0] S_RELEASE = 3'd4;

   localparam int              BW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [7:0]      DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [BW-1:0]   BIT_LAST = BW'(DATA_WIDTH - 1);

   logic [2:0]            state;
   logic [7:0]            div_cnt;
   logic [BW-1:0]         bit_cnt;
   logic [DATA_WIDTH-1:0] tx_shift;
   logic [DATA_WIDTH-1:0] rx_shift;
   logic                  last_q;
   logic                  sclk_q;
   logic                  mosi_q;
   logic                  cs_n_q;
   logic                  busy_q;
   logic                  done_q;
   logic [DATA_WIDTH-1:0] rx_q;
   logic                  div_wrap;

   assign div_wrap    = (div_cnt == DIV_LAST);
   assign bus.sclk    = sclk_q;
   assign bus.mosi    = mosi_q;
   assign bus.cs_n    = cs_n_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.rx_data = rx_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         div_cnt  <= '0;
         bit_cnt  <= '0;
         tx_shift <= '0;
         rx_shift <= '0;
         last_q   <= 1'b0;
         sclk_q   <= 1'b0;
         mosi_q   <= 1'b0;
         cs_n_q   <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         rx_q     <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            // HOLD keeps cs_n low; busy stays high through the done cycle so a start there is ignored
            S_IDLE, S_HOLD: begin
               busy_q <= 1'b0;
               if (bus.start && !busy_q) begin
                  tx_shift <= bus.tx_data << 1;
                  last_q   <= bus.last;
                  mosi_q   <= bus.tx_data[DATA_WIDTH-1];
                  cs_n_q   <= 1'b0;
                  busy_q   <= 1'b1;
                  div_cnt  <= '0;
                  bit_cnt  <= '0;
                  state    <= S_SETUP;
               end
            end

            S_SETUP: begin
               if (div_wrap) begin
                  div_cnt  <= '0;
                  sclk_q   <= 1'b1;
                  rx_shift <= {rx_shift[DATA_WIDTH-2:0], bus.miso};
                  state    <= S_SHIFT;
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end

            S_SHIFT: begin
               if (div_wrap) begin
                  div_cnt <= '0;
                  sclk_q  <= ~sclk_q;
                  if (!sclk_q) begin
                     rx_shift <= {rx_shift[DATA_WIDTH-2:0], bus.miso};
                  end else if (bit_cnt == BIT_LAST) begin
                     done_q <= 1'b1;
                     rx_q   <= rx_shift;
                     state  <= last_q ? S_RELEASE : S_HOLD;
                  end else begin
                     bit_cnt  <= bit_cnt + BW'(1);
                     mosi_q   <= tx_shift[DATA_WIDTH-1];
                     tx_shift <= tx_shift << 1;
                  end
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end

            S_RELEASE: begin
               if (div_wrap) begin
                  div_cnt <= '0;
                  cs_n_q  <= 1'b1;
                  mosi_q  <= 1'b0;
                  busy_q  <= 1'b0;
                  state   <= S_IDLE;
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_snn_cfg_spi_master.sv
// tb/tb_snn_cfg_spi_master.sv - scoreboard bench for snn_cfg_spi_master at CLK_DIV=2 and CLK_DIV=1
module tb_snn_cfg_spi_master;
   localparam int W  = 8;
   localparam int D0 = 2;
   localparam int D1 = 1;

   localparam int S_DONE  = 0;
   localparam int S_RX    = 1;
   localparam int S_CSN   = 2;
   localparam int S_BUSY  = 3;
   localparam int S_SCLK  = 4;
   localparam int S_MOSI  = 5;
   localparam int S_EDGES = 6;

   typedef struct {
      int cyc;
      int inst;
      int sig;
      int exp;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   int   vectors     = 0;
   int   miscompares = 0;
   int   max_cyc     = 0;
   exp_t sb[$];
   exp_t keep_q[$];

   int         model_edges[2];
   logic [7:0] model_rx[2];
   int         edges0 = 0;
   int         edges1 = 0;
   int         rise0  = 0;
   bit         resp_mode0 = 1'b0;
   logic [7:0] resp_byte0 = 8'h00;

   snn_cfg_spi_master_if #(.DATA_WIDTH(W)) b0 ();
   snn_cfg_spi_master_if #(.DATA_WIDTH(W)) b1 ();

   snn_cfg_spi_master #(.CLK_DIV(D0), .DATA_WIDTH(W)) u0 (.clk(clk), .reset(reset), .bus(b0.master));
   snn_cfg_spi_master #(.CLK_DIV(D1), .DATA_WIDTH(W)) u1 (.clk(clk), .reset(reset), .bus(b1.master));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge b0.sclk) edges0 <= edges0 + 1;
   always @(posedge b1.sclk) edges1 <= edges1 + 1;

   // responder: presents its byte MSB first, advancing one bit per sclk rising edge since cs_n fell
   always @(posedge b0.sclk or posedge b0.cs_n) begin
      if (b0.cs_n) rise0 <= 0;
      else         rise0 <= rise0 + 1;
   end
   assign b0.miso = resp_mode0 ? resp_byte0[3'(7 - (rise0 % 8))] : b0.mosi;
   assign b1.miso = b1.mosi;

   function automatic int get_sig(input int inst, input int sig);
      int v;
      v = 0;
      case (sig)
         S_DONE:  v = (inst == 0) ? int'(b0.done)    : int'(b1.done);
         S_RX:    v = (inst == 0) ? int'(b0.rx_data) : int'(b1.rx_data);
         S_CSN:   v = (inst == 0) ? int'(b0.cs_n)    : int'(b1.cs_n);
         S_BUSY:  v = (inst == 0) ? int'(b0.busy)    : int'(b1.busy);
         S_SCLK:  v = (inst == 0) ? int'(b0.sclk)    : int'(b1.sclk);
         S_MOSI:  v = (inst == 0) ? int'(b0.mosi)    : int'(b1.mosi);
         S_EDGES: v = (inst == 0) ? edges0           : edges1;
         default: v = -1;
      endcase
      return v;
   endfunction

   function automatic string sig_name(input int sig);
      case (sig)
         S_DONE:  return "done";
         S_RX:    return "rx_data";
         S_CSN:   return "cs_n";
         S_BUSY:  return "busy";
         S_SCLK:  return "sclk";
         S_MOSI:  return "mosi";
         S_EDGES: return "sclk_rises";
         default: return "unknown";
      endcase
   endfunction

   task automatic push(input int inst, input int c, input int sig, input int e);
      exp_t item;
      item.cyc  = c;
      item.inst = inst;
      item.sig  = sig;
      item.exp  = e;
      sb.push_back(item);
      if (c > max_cyc) max_cyc = c;
   endtask

   task automatic drive(input int inst, input bit s, input logic [7:0] tx, input bit l);
      if (inst == 0) begin
         b0.start = s; b0.tx_data = tx; b0.last = l;
      end else begin
         b1.start = s; b1.tx_data = tx; b1.last = l;
      end
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Reference timing: spec cycle T+k is observed at the negedge where cyc == e+k-1
   task automatic issue(input int inst, input logic [7:0] tx, input bit l, input logic [7:0] rx_exp,
                        input bit full, output int e, output int idle);
      int d;
      int cd;
      d    = (inst == 0) ? D0 : D1;
      e    = cyc + 1;
      idle = e;
      push(inst, e, S_CSN, 0);
      push(inst, e, S_BUSY, 1);
      push(inst, e, S_MOSI, int'(tx[7]));
      if (full) begin
         for (int k = 0; k < 8; k++) begin
            push(inst, e + d + 2*k*d, S_SCLK, 1);
            push(inst, e + d + 2*k*d, S_MOSI, int'(tx[7-k]));
            if (k < 7) push(inst, e + 2*d + 2*k*d, S_SCLK, 0);
         end
         push(inst, e + 8*d - 1, S_RX, int'(model_rx[inst]));
         cd = e + 16*d;
         push(inst, cd, S_DONE, 1);
         push(inst, cd, S_RX, int'(rx_exp));
         push(inst, cd, S_BUSY, 1);
         push(inst, cd, S_SCLK, 0);
         model_rx[inst]    = rx_exp;
         model_edges[inst] = model_edges[inst] + 8;
         if (l) begin
            push(inst, e + 17*d - 1, S_CSN, 0);
            push(inst, e + 17*d - 1, S_BUSY, 1);
            push(inst, e + 17*d, S_CSN, 1);
            push(inst, e + 17*d, S_BUSY, 0);
            push(inst, e + 17*d, S_MOSI, 0);
            push(inst, e + 17*d, S_EDGES, model_edges[inst]);
            idle = e + 17*d;
         end else begin
            push(inst, cd + 1, S_BUSY, 0);
            push(inst, cd + 1, S_CSN, 0);
            push(inst, cd + 1, S_SCLK, 0);
            push(inst, cd + 1, S_MOSI, int'(tx[0]));
            idle = cd + 1;
         end
      end
      drive(inst, 1'b1, tx, l);
      @(negedge clk);
      drive(inst, 1'b0, 8'($urandom), 1'($urandom));
   endtask

   initial begin : monitor
      int  act;
      bit  seen0;
      bit  seen1;
      forever begin
         @(negedge clk);
         keep_q.delete();
         seen0 = 1'b0;
         seen1 = 1'b0;
         foreach (sb[i]) begin
            if (sb[i].cyc == cyc) begin
               act = get_sig(sb[i].inst, sb[i].sig);
               vectors++;
               if (act != sb[i].exp) begin
                  miscompares++;
                  $display("FAIL %s u%0d cyc=%0d: got 0x%0h, expected 0x%0h",
                           sig_name(sb[i].sig), sb[i].inst, cyc, act, sb[i].exp);
               end
               if (sb[i].sig == S_DONE) begin
                  if (sb[i].inst == 0) seen0 = 1'b1;
                  else                 seen1 = 1'b1;
               end
            end else if (sb[i].cyc < cyc) begin
               vectors++;
               miscompares++;
               $display("FAIL stale_%s u%0d: check for cyc=%0d never sampled (now %0d)",
                        sig_name(sb[i].sig), sb[i].inst, sb[i].cyc, cyc);
            end else begin
               keep_q.push_back(sb[i]);
            end
         end
         sb = keep_q;
         if (b0.done === 1'b1 && !seen0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_done u0 cyc=%0d: got 1, expected 0", cyc);
         end
         if (b1.done === 1'b1 && !seen1) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_done u1 cyc=%0d: got 1, expected 0", cyc);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit at cyc=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int         e;
      int         idle;
      int         r;
      bit         l;
      logic [7:0] tx;
      logic [7:0] rb;

      model_edges[0] = 0; model_edges[1] = 0;
      model_rx[0]    = 8'h00; model_rx[1] = 8'h00;
      drive(0, 1'b0, 8'h00, 1'b0);
      drive(1, 1'b0, 8'h00, 1'b0);
      reset = 1'b1;

      @(negedge clk);
      wait_cyc(2);
      for (int i = 0; i < 2; i++) begin
         push(i, 3, S_CSN, 1);
         push(i, 3, S_SCLK, 0);
         push(i, 3, S_MOSI, 0);
         push(i, 3, S_BUSY, 0);
         push(i, 3, S_DONE, 0);
         push(i, 3, S_RX, 0);
         push(i, 3, S_EDGES, 0);
      end
      reset = 1'b0;
      wait_cyc(5);

      // loopback 0xA5, single byte frame
      resp_mode0 = 1'b0;
      issue(0, 8'hA5, 1'b1, 8'hA5, 1'b1, e, idle);
      wait_cyc(idle);

      // responder returns 0x3C while 0xFF is sent
      resp_mode0 = 1'b1;
      resp_byte0 = 8'h3C;
      issue(0, 8'hFF, 1'b1, 8'h3C, 1'b1, e, idle);
      wait_cyc(idle + 1);

      // two-byte frame, second start three cycles after the first done
      resp_mode0 = 1'b0;
      issue(0, 8'h12, 1'b0, 8'h12, 1'b1, e, idle);
      push(0, idle + 1, S_CSN, 0);
      wait_cyc(idle + 1);
      issue(0, 8'h34, 1'b1, 8'h34, 1'b1, e, idle);
      wait_cyc(idle + 2);

      // starts while busy must be ignored
      issue(0, 8'hC3, 1'b1, 8'hC3, 1'b1, e, idle);
      wait_cyc(e + 4);
      drive(0, 1'b1, 8'h00, 1'b1);
      @(negedge clk);
      drive(0, 1'b0, 8'h00, 1'b0);
      wait_cyc(e + 9);
      drive(0, 1'b1, 8'h00, 1'b0);
      @(negedge clk);
      drive(0, 1'b0, 8'h00, 1'b0);
      wait_cyc(idle + 2);

      // reset during the 4th bit aborts the byte without a done pulse
      resp_mode0 = 1'b1;
      resp_byte0 = 8'h96;
      issue(0, 8'h6B, 1'b1, 8'h00, 1'b0, e, idle);
      r = e + 7*D0 + 1;
      wait_cyc(r - 1);
      model_rx[0] = 8'h00;
      model_rx[1] = 8'h00;
      model_edges[0] = model_edges[0] + 4;
      push(0, r, S_CSN, 1);
      push(0, r, S_SCLK, 0);
      push(0, r, S_BUSY, 0);
      push(0, r, S_DONE, 0);
      push(0, r, S_RX, 0);
      push(0, r, S_EDGES, model_edges[0]);
      push(1, r, S_RX, 0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      wait_cyc(r + 3);
      resp_byte0 = 8'hA7;
      issue(0, 8'h81, 1'b1, 8'hA7, 1'b1, e, idle);
      wait_cyc(idle + 1);

      // CLK_DIV=1 instance, loopback 0x55
      issue(1, 8'h55, 1'b1, 8'h55, 1'b1, e, idle);
      wait_cyc(idle + 1);

      for (int i = 0; i < 24; i++) begin
         tx = 8'($urandom);
         rb = 8'($urandom);
         l  = (i == 23) ? 1'b1 : 1'($urandom_range(0, 1));
         resp_mode0 = 1'($urandom_range(0, 1));
         resp_byte0 = rb;
         issue(0, tx, l, resp_mode0 ? rb : tx, 1'b1, e, idle);
         wait_cyc(idle + $urandom_range(0, 3));
      end

      for (int i = 0; i < 12; i++) begin
         tx = 8'($urandom);
         l  = (i == 11) ? 1'b1 : 1'($urandom_range(0, 1));
         issue(1, tx, l, tx, 1'b1, e, idle);
         wait_cyc(idle + $urandom_range(0, 3));
      end

      wait_cyc(max_cyc + 3);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
